// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
//   Bundles the request/response handshake between the datapath and the
//   memory access controller, together with the single-port memory bus the
//   controller drives.
//
//   Handshake: a request transfers on a rising edge where req_valid=1 and
//   req_ready=1; the requester holds req_* stable until that edge.
//   rsp_valid is a one-cycle completion pulse with no back-pressure, and
//   rsp_rdata is only meaningful while rsp_valid=1.
//
//   Modports:
//     master - requester side plus memory model (drives req_*, mem_dataout)
//     slave  - the controller (drives req_ready, rsp_*, mem_address,
//              mem_datain, mem_write)
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_datain;
  logic              mem_write;
  logic [DATA_W-1:0] mem_dataout;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_dataout,
    input  req_ready, rsp_valid, rsp_rdata, mem_address, mem_datain, mem_write
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_dataout,
    output req_ready, rsp_valid, rsp_rdata, mem_address, mem_datain, mem_write
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//   CPU-side initiator for a single-port memory with combinational read and
//   rising-edge write. Owns MAR/MDR and turns one-word read/write requests
//   into memory cycles: IDLE -> SETUP (WAIT_CYCLES cycles, skipped if 0)
//   -> ACCESS (one cycle) -> RESP (one cycle) -> IDLE.
//
//   Ports:
//     clk      - system clock, rising-edge active
//     reset_n  - asynchronous active-low reset
//     bus      - mem_access_ctrl_if.slave (request/response + memory bus)
//     state_o  - current FSM state, for debug/observation
//
//   Parameters: ADDR_W, DATA_W, WAIT_CYCLES (address-setup cycles, 0..15).
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mem_access_ctrl_if.slave     bus,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // The counter is 4 bits wide; WAIT_CYCLES above 15 is outside the legal
  // range and is simply truncated here.
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e            state_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q;
  logic              wr_q;
  logic [3:0]        cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            mar_q <= bus.req_addr;
            wr_q  <= bus.req_write;
            cnt_q <= WAIT_INIT;
            // Reads leave MDR alone so rsp_rdata keeps the last result
            // until the new read data is captured.
            if (bus.req_write) begin
              mdr_q <= bus.req_wdata;
            end
            state_q <= (WAIT_INIT == 4'd0) ? ACCESS : SETUP;
          end
        end
        SETUP: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          // Memory read is combinational, so data is valid during ACCESS
          // and captured on its closing edge.
          if (!wr_q) begin
            mdr_q <= bus.mem_dataout;
          end
          state_q <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // All outputs decode registered state only, so an asynchronous reset
  // drops mem_write at once and no combinational path reaches the bus.
  assign bus.req_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_rdata   = mdr_q;
  assign bus.mem_address = mar_q;
  assign bus.mem_datain  = mdr_q;
  assign bus.mem_write   = (state_q == ACCESS) && wr_q;
  assign state_o         = state_q;

endmodule
